// File: rtl/prog_mon_pkg.sv
// Shared types and default sizes for the counter-bus monitor.
package prog_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK
  } mon_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ERR_W      = 8;

endpackage

// File: rtl/prog_mon_fifo.sv
// Show-ahead sample FIFO with a registered head; the head holds its last value when empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module prog_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             full,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic             pop;
  logic             push_ok;
  logic [WIDTH-1:0] head_nxt;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = pop_ready && out_valid;
  assign push_ok   = push && (!full || pop);
  assign rd_next   = rd_ptr + 1'b1;

  // The head register follows the entry that will be at the front after this cycle.
  always_comb begin
    head_nxt = out_data;
    if (pop && (count > (AW+1)'(1))) begin
      head_nxt = mem[rd_next];
    end else if (push_ok && ((count == '0) || pop)) begin
      head_nxt = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      out_data <= head_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prog_count_monitor.sv
// Checks that the count seen on the shared bus increments by one, excusing the step after a load.
// Sample FIFO and overflow flag exist only when PROG_MON_FIFO_EN is defined.
module prog_count_monitor
  import prog_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_oe,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             load_seen,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic             ovf_flag,
  output logic             smp_valid,
  output logic [WIDTH-1:0] smp_data,
  input  logic             smp_ready
);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] exp_nxt;
  logic             mismatch;
  logic             capture;

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_val;
    mismatch  = 1'b0;
    capture   = 1'b0;
    if (!bus_oe) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          capture   = 1'b1;
          exp_nxt   = bus_data + WIDTH'(1);
          state_nxt = TRACK;
        end
        TRACK: begin
          capture = 1'b1;
          if (bus_data == exp_val) begin
            exp_nxt = exp_val + WIDTH'(1);
          end else begin
            mismatch = 1'b1;
            exp_nxt  = bus_data + WIDTH'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
      // The bus carries the loaded value next cycle, so that sample must re-acquire.
      if (load_seen) begin
        state_nxt = ACQUIRE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      exp_val   <= '0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      state   <= state_nxt;
      exp_val <= exp_nxt;
      locked  <= (state_nxt == TRACK);
      if (mismatch) begin
        err_flag <= 1'b1;
        if (clr_err) begin
          err_count <= ERR_W'(1);
        end else if (!(&err_count)) begin
          err_count <= err_count + ERR_W'(1);
        end
      end else if (clr_err) begin
        err_flag  <= 1'b0;
        err_count <= '0;
      end
    end
  end

`ifdef PROG_MON_FIFO_EN
  logic fifo_full;
  logic drop;

  prog_mon_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (bus_data),
    .pop_ready (smp_ready),
    .full      (fifo_full),
    .out_valid (smp_valid),
    .out_data  (smp_data)
  );

  // A full FIFO is never empty, so a ready consumer always frees a slot this cycle.
  assign drop = capture && fifo_full && !smp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
    end else if (clr_err) begin
      ovf_flag <= 1'b0;
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic unused_sig;

  assign unused_sig = ^{smp_ready, capture};
  assign smp_valid  = 1'b0;
  assign smp_data   = '0;
  assign ovf_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_prog_count_monitor.sv
// Directed plus randomized bench for prog_count_monitor against a sample-history reference model.
module tb_prog_count_monitor;

  localparam int W       = 8;
  localparam int ERR_W   = 8;
  localparam int DEPTH   = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             bus_oe;
  logic [W-1:0]     bus_data;
  logic             load_seen;
  logic             clr_err;
  logic             locked;
  logic             err_flag;
  logic [ERR_W-1:0] err_count;
  logic             ovf_flag;
  logic             smp_valid;
  logic [W-1:0]     smp_data;
  logic             smp_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current bus_oe run, previous sample and its load flag.
  int           run;
  logic [W-1:0] prev_d;
  bit           prev_load;
  bit           m_locked;
  bit           m_errf;
  int           m_errc;
  bit           m_ovf;
  logic [W-1:0] q[$];
  logic [W-1:0] m_head;
  bit           fifo_en;

  prog_count_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .bus_oe    (bus_oe),
    .bus_data  (bus_data),
    .load_seen (load_seen),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_flag  (err_flag),
    .err_count (err_count),
    .ovf_flag  (ovf_flag),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .smp_ready (smp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run       = 0;
    prev_d    = '0;
    prev_load = 1'b0;
    m_locked  = 1'b0;
    m_errf    = 1'b0;
    m_errc    = 0;
    m_ovf     = 1'b0;
    q.delete();
    m_head    = '0;
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.locked", tag), locked, m_locked);
    check($sformatf("%s.err_flag", tag), err_flag, m_errf);
    check($sformatf("%s.err_count", tag), err_count, m_errc);
    check($sformatf("%s.ovf_flag", tag), ovf_flag, m_ovf);
    check($sformatf("%s.smp_valid", tag), smp_valid, fifo_en && (q.size() != 0));
    check($sformatf("%s.smp_data", tag), smp_data, fifo_en ? m_head : '0);
  endtask

  task automatic step(input bit oe, input logic [W-1:0] d, input bit ld, input bit clr,
                      input bit rdy, input string tag);
    bit           captured;
    bit           checked;
    bit           mism;
    bit           drop;
    logic [W-1:0] nx;
    bus_oe    = oe;
    bus_data  = d;
    load_seen = ld;
    clr_err   = clr;
    smp_ready = rdy;
    @(posedge clk);
    run      = oe ? run + 1 : 0;
    captured = oe && (run >= 2);
    checked  = oe && (run >= 3) && !prev_load;
    nx       = prev_d + W'(1);
    mism     = checked && (d != nx);
    m_locked = oe && (run >= 2) && !ld;
    if (mism) begin
      m_errf = 1'b1;
      m_errc = clr ? 1 : ((m_errc < ERR_MAX) ? m_errc + 1 : ERR_MAX);
    end else if (clr) begin
      m_errf = 1'b0;
      m_errc = 0;
    end
    if (fifo_en) begin
      if ((q.size() > 0) && rdy) void'(q.pop_front());
      drop = captured && (q.size() >= DEPTH);
      if (captured && !drop) q.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (q.size() > 0) m_head = q[0];
    end
    if (oe) prev_d = d;
    prev_load = oe && ld;
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] cnt;
    logic [W-1:0] dv;
    bit           oe_r;
    bit           ld_r;
    fifo_en = 1'b0;
`ifdef PROG_MON_FIFO_EN
    fifo_en = 1'b1;
`endif
    reset     = 1'b1;
    bus_oe    = 1'b0;
    bus_data  = '0;
    load_seen = 1'b0;
    clr_err   = 1'b0;
    smp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Acquire on 11, FIFO keeps 11,12,13.
    step(1, 8'd10, 0, 0, 0, "acq10");
    check("acq10_not_locked", locked, 1'b0);
    step(1, 8'd11, 0, 0, 0, "acq11");
    check("locked_after_11", locked, 1'b1);
    step(1, 8'd12, 0, 0, 0, "acq12");
    step(1, 8'd13, 0, 0, 0, "acq13");
    check("acq_no_err", err_count, 0);
`ifdef PROG_MON_FIFO_EN
    check("fifo_head_11", smp_data, 11);
`endif
    for (int i = 0; i < 4; i++) step(0, 8'd0, 0, 0, 1, "drain1");

    // Wrap-around 255 -> 0 is a match.
    for (int i = 0; i < 6; i++) step(1, W'(252 + i), 0, 0, 1, "wrap");
    check("wrap_no_err", err_count, 0);
    check("wrap_no_flag", err_flag, 1'b0);
    step(0, 8'd0, 0, 0, 1, "gap1");

    // 9 is a mismatch, 10 resyncs cleanly.
    step(1, 8'd5, 0, 0, 1, "m5");
    step(1, 8'd6, 0, 0, 1, "m6");
    step(1, 8'd9, 0, 0, 1, "m9");
    check("mis9_flag", err_flag, 1'b1);
    check("mis9_count", err_count, 1);
    step(1, 8'd10, 0, 0, 1, "m10");
    check("mis10_count", err_count, 1);
    step(0, 8'd0, 0, 0, 1, "gap2");

    // Load on 21 excuses the jump to 100.
    step(1, 8'd20, 0, 0, 1, "l20");
    step(1, 8'd21, 1, 0, 1, "l21");
    check("load_unlocks", locked, 1'b0);
    step(1, 8'd100, 0, 0, 1, "l100");
    step(1, 8'd101, 0, 0, 1, "l101");
    check("load_no_err", err_count, 1);
    step(0, 8'd0, 0, 1, 1, "clr1");
    check("clr_count", err_count, 0);

    // Stalled consumer: four samples kept, fifth dropped.
    for (int i = 0; i < 7; i++) step(1, W'(30 + i), 0, 0, 0, "ovf");
`ifdef PROG_MON_FIFO_EN
    check("ovf_set", ovf_flag, 1'b1);
`endif
    step(0, 8'd0, 0, 1, 0, "ovf_clr");
    check("ovf_cleared", ovf_flag, 1'b0);
`ifdef PROG_MON_FIFO_EN
    check("ovf_head_31", smp_data, 31);
`endif
    for (int i = 0; i < 5; i++) step(0, 8'd0, 0, 0, 1, "drain2");

    // Randomized traffic: mostly counting, occasional jumps, loads, clears and gaps.
    cnt = W'($urandom);
    for (int i = 0; i < 600; i++) begin
      oe_r = ($urandom_range(0, 9) != 0);
      ld_r = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) cnt = W'($urandom);
      dv = cnt;
      step(oe_r, dv, ld_r, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), "rand");
      cnt = (ld_r || !oe_r) ? W'($urandom) : cnt + W'(1);
    end
    step(0, 8'd0, 0, 1, 1, "clr2");

    // Continuous mismatches saturate the counter.
    for (int i = 0; i < 305; i++) step(1, W'(i * 2), 0, 0, 1, "sat");
    check("sat_count", err_count, ERR_MAX);
    check("sat_flag", err_flag, 1'b1);

    // Asynchronous reset mid-stream.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("midreset");
    check("midreset_count", err_count, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 8'd40, 0, 0, 1, "post0");
    step(1, 8'd41, 0, 0, 1, "post1");
    step(1, 8'd42, 0, 0, 1, "post2");
    check("post_locked", locked, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
